// File: rtl/rr_arb.sv
// rr_arb - round-robin arbiter with grant hold.
//
// Shares one resource among REQ requesters. The next owner is chosen by a
// rotated priority search that starts just after the previous winner. An
// owner keeps the grant until it asserts done or the hold timeout expires.
// A release with requests pending re-arbitrates on the same edge, so there
// is no idle cycle between owners.
//
// Ports
//   clk          rising-edge clock
//   reset_       synchronous, active-low reset
//   req[REQ]     per-requester request, active high
//   done         current owner releases the resource (ignored when idle)
//   grant[REQ]   registered one-hot grant, all-zero when idle
//   grant_valid  registered, high while a grant is active
//   grant_id     registered binary owner index, 0 when idle
//   expire       one-cycle pulse: previous grant was revoked by timeout
module rr_arb #(
  parameter int unsigned REQ      = 8,
  parameter int unsigned REQ_W    = $clog2(REQ),
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [REQ-1:0]   req,
  input  logic             done,
  output logic [REQ-1:0]   grant,
  output logic             grant_valid,
  output logic [REQ_W-1:0] grant_id,
  output logic             expire
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t             state, state_nxt;
  logic [REQ_W-1:0]   last_id, last_id_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [REQ-1:0]     grant_nxt;
  logic               grant_valid_nxt;
  logic [REQ_W-1:0]   grant_id_nxt;
  logic               expire_nxt;

  logic [REQ_W-1:0]   win_id;
  logic               any_req;
  logic               timeout;
  logic               release_ev;

  // Rotated search: offsets 1..REQ from last_id. Offset REQ lands on last_id
  // itself, so the previous winner only wins again when it is alone.
  always_comb begin
    win_id  = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= REQ; k++) begin
      if (!any_req && req[(32'(last_id) + k) % REQ]) begin
        any_req = 1'b1;
        win_id  = REQ_W'((32'(last_id) + k) % REQ);
      end
    end
  end

  // A done in the timeout cycle takes precedence, so expire stays low then.
  assign timeout    = (MAX_HOLD != 0) && (state == BUSY) &&
                      (hold_cnt == HOLD_LAST) && !done;
  assign release_ev = (state == BUSY) && (done || timeout);

  always_comb begin
    state_nxt       = state;
    last_id_nxt     = last_id;
    hold_cnt_nxt    = hold_cnt;
    grant_nxt       = '0;
    grant_valid_nxt = 1'b0;
    grant_id_nxt    = '0;
    expire_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt       = BUSY;
          last_id_nxt     = win_id;
          hold_cnt_nxt    = '0;
          grant_nxt       = REQ'(1) << win_id;
          grant_valid_nxt = 1'b1;
          grant_id_nxt    = win_id;
        end
      end
      BUSY: begin
        if (release_ev) begin
          expire_nxt = timeout;
          if (any_req) begin
            last_id_nxt     = win_id;
            hold_cnt_nxt    = '0;
            grant_nxt       = REQ'(1) << win_id;
            grant_valid_nxt = 1'b1;
            grant_id_nxt    = win_id;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          grant_nxt       = grant;
          grant_valid_nxt = grant_valid;
          grant_id_nxt    = grant_id;
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state       <= IDLE;
      last_id     <= REQ_W'(REQ - 1);
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      expire      <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_id     <= last_id_nxt;
      hold_cnt    <= hold_cnt_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      grant_id    <= grant_id_nxt;
      expire      <= expire_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb - bench for rr_arb (REQ=8, MAX_HOLD=4).
// An integer-level model of owner / last winner / cycles-held is compared
// against the DUT on every cycle; directed vectors add literal expectations.
module tb_rr_arb;

  localparam int REQ = 8;
  localparam int MH  = 4;

  logic           clk = 1'b0;
  logic           reset_;
  logic [REQ-1:0] req;
  logic           done;
  logic [REQ-1:0] grant;
  logic           grant_valid;
  logic [2:0]     grant_id;
  logic           expire;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arb #(.REQ(REQ), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .expire     (expire)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1: nobody owns the resource
  int m_last  = REQ - 1;
  int m_held  = 0;    // grant cycles elapsed, 1 in the first granted cycle
  bit m_exp   = 1'b0;

  function automatic int pick(input logic [REQ-1:0] r, input int last);
    for (int d = 1; d <= REQ; d++) begin
      if (r[(last + d) % REQ]) return (last + d) % REQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    bit to;
    if (!reset_) begin
      m_owner = -1; m_last = REQ - 1; m_held = 0; m_exp = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (m_owner < 0) begin
        if (req != 0) begin
          m_owner = pick(req, m_last); m_last = m_owner; m_held = 1;
        end
      end else begin
        to = (m_held == MH) && !done;
        if (done || to) begin
          m_exp = to;
          if (req != 0) begin
            m_owner = pick(req, m_last); m_last = m_owner; m_held = 1;
          end else begin
            m_owner = -1;
          end
        end else begin
          m_held++;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  initial begin
    logic [REQ-1:0] eg;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eg = (m_owner < 0) ? '0 : (REQ'(1) << m_owner);
      cmp("model_grant", 32'(grant), 32'(eg));
      cmp("model_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
      cmp("model_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      cmp("model_expire", 32'(expire), 32'(m_exp));
      cmp("consistency", 32'(grant),
          grant_valid ? 32'(REQ'(1) << grant_id) : 32'd0);
    end
  end

  // apply inputs at a negedge, return at the next negedge
  task automatic cyc(input logic [REQ-1:0] r, input logic d);
    req = r; done = d;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [REQ-1:0] g, input int id, input logic v,
                     input logic e);
    cmp({name, "_grant"}, 32'(grant), 32'(g));
    cmp({name, "_id"}, 32'(grant_id), 32'(id));
    cmp({name, "_valid"}, 32'(grant_valid), 32'(v));
    cmp({name, "_expire"}, 32'(expire), 32'(e));
  endtask

  initial begin
    reset_ = 1'b0; req = 8'hFF; done = 1'b1;
    @(negedge clk);
    // reset with requests and done asserted
    repeat (3) cyc(8'hFF, 1'b1);
    lit("reset", 8'h00, 0, 1'b0, 1'b0);
    reset_ = 1'b1;
    cyc(8'hFF, 1'b0);
    lit("first", 8'h01, 0, 1'b1, 1'b0);

    // rotation 1..7 then wrap to 0
    for (int k = 0; k < 8; k++) begin
      cyc(8'hFF, 1'b1);
      cmp("rot_id", 32'(grant_id), 32'((k + 1) % 8));
    end
    // alternating 7,0,7,0
    for (int k = 0; k < 4; k++) begin
      cyc(8'h81, 1'b1);
      cmp("wrap_id", 32'(grant_id), (k % 2 == 0) ? 32'd7 : 32'd0);
    end
    cyc(8'h00, 1'b1);
    lit("to_idle", 8'h00, 0, 1'b0, 1'b0);

    // single requester, grant held after req drops
    cyc(8'h20, 1'b0);
    lit("single", 8'h20, 5, 1'b1, 1'b0);
    cyc(8'h00, 1'b0);
    lit("held", 8'h20, 5, 1'b1, 1'b0);
    cyc(8'h00, 1'b1);
    lit("released", 8'h00, 0, 1'b0, 1'b0);

    // back-to-back handover
    cyc(8'h04, 1'b0);
    lit("b2b_a", 8'h04, 2, 1'b1, 1'b0);
    cyc(8'h14, 1'b1);
    lit("b2b_b", 8'h10, 4, 1'b1, 1'b0);
    cyc(8'h04, 1'b1);
    lit("b2b_c", 8'h04, 2, 1'b1, 1'b0);
    cyc(8'h00, 1'b1);

    // timeout: id 0 shown 4 cycles, then id 1 with expire
    cyc(8'h03, 1'b0);
    lit("to_g0", 8'h01, 0, 1'b1, 1'b0);
    repeat (3) begin
      cyc(8'h03, 1'b0);
      lit("to_hold", 8'h01, 0, 1'b1, 1'b0);
    end
    cyc(8'h03, 1'b0);
    lit("to_expire", 8'h02, 1, 1'b1, 1'b1);
    repeat (3) begin
      cyc(8'h03, 1'b0);
      lit("to_hold1", 8'h02, 1, 1'b1, 1'b0);
    end
    // done coincides with timeout: normal release
    cyc(8'h03, 1'b1);
    lit("to_done", 8'h01, 0, 1'b1, 1'b0);
    // timeout with nobody waiting
    repeat (3) cyc(8'h00, 1'b0);
    lit("to_last", 8'h01, 0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0);
    lit("to_idle_exp", 8'h00, 0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0);
    lit("idle_again", 8'h00, 0, 1'b0, 1'b0);

    // reset during a grant
    cyc(8'h08, 1'b0);
    lit("pre_rst", 8'h08, 3, 1'b1, 1'b0);
    reset_ = 1'b0;
    cyc(8'h08, 1'b0);
    lit("mid_rst", 8'h00, 0, 1'b0, 1'b0);
    reset_ = 1'b1;
    cyc(8'h08, 1'b0);
    lit("post_rst", 8'h08, 3, 1'b1, 1'b0);
    cyc(8'h00, 1'b1);

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
